// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: hazard-unit view of the pipeline stage signals
interface pipeline_hazard_controller_if;
  logic [4:0]  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic        REG_W_En_E, REG_W_En_M, REG_W_En_W;
  logic [1:0]  Result_Src_Sel_E;
  logic        Mispredict_E, MEM_Req_M, MEM_Ready_M;
  logic        Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E;
  logic [1:0]  Forward_A_E, Forward_B_E;
  logic [15:0] Stall_Count, Flush_Count;
  logic        Mem_Timeout;
  modport master (
    output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W,
    output REG_W_En_E, REG_W_En_M, REG_W_En_W, Result_Src_Sel_E,
    output Mispredict_E, MEM_Req_M, MEM_Ready_M,
    input  Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E,
    input  Forward_A_E, Forward_B_E, Stall_Count, Flush_Count, Mem_Timeout
  );
  modport slave (
    input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W,
    input  REG_W_En_E, REG_W_En_M, REG_W_En_W, Result_Src_Sel_E,
    input  Mispredict_E, MEM_Req_M, MEM_Ready_M,
    output Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E,
    output Forward_A_E, Forward_B_E, Stall_Count, Flush_Count, Mem_Timeout
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: forwarding, stall/flush control, memory-wait FSM and perf counters
module pipeline_hazard_controller (
  input  logic CLK,
  input  logic RST_N,
  pipeline_hazard_controller_if.slave hz
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;
  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        timeout_q, timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic        mem_stall, run_free, flush_mp, load_use;
  // hazard detection with priority memory stall > mispredict > load-use
  always_comb begin
    mem_stall = state_q == TIMEOUT || (!hz.MEM_Ready_M && (state_q == MEM_WAIT || (state_q == RUN && hz.MEM_Req_M)));
    run_free  = state_q == RUN && !mem_stall;
    flush_mp  = run_free && hz.Mispredict_E;
    load_use  = run_free && !hz.Mispredict_E && hz.Result_Src_Sel_E == 2'b01 && hz.REG_W_En_E &&
                hz.RD_E != 5'd0 && (hz.RD_E == hz.RS1_D || hz.RD_E == hz.RS2_D);
  end
  assign hz.Stall_F     = RST_N && (mem_stall || load_use);
  assign hz.Stall_D     = RST_N && (mem_stall || load_use);
  assign hz.Stall_E     = RST_N && mem_stall;
  assign hz.Stall_M     = RST_N && mem_stall;
  assign hz.Flush_D     = !RST_N || flush_mp;
  assign hz.Flush_E     = !RST_N || flush_mp || load_use;
  assign hz.Forward_A_E = !RST_N ? 2'b00 :
                          (hz.REG_W_En_M && hz.RD_M != 5'd0 && hz.RD_M == hz.RS1_E) ? 2'b10 :
                          (hz.REG_W_En_W && hz.RD_W != 5'd0 && hz.RD_W == hz.RS1_E) ? 2'b01 : 2'b00;
  assign hz.Forward_B_E = !RST_N ? 2'b00 :
                          (hz.REG_W_En_M && hz.RD_M != 5'd0 && hz.RD_M == hz.RS2_E) ? 2'b10 :
                          (hz.REG_W_En_W && hz.RD_W != 5'd0 && hz.RD_W == hz.RS2_E) ? 2'b01 : 2'b00;
  assign hz.Stall_Count = stall_cnt_q;
  assign hz.Flush_Count = flush_cnt_q;
  assign hz.Mem_Timeout = timeout_q;
  // next state: a wait starts at count 1 and times out after the 256th stalled cycle
  always_comb begin
    state_d     = state_q == TIMEOUT ? TIMEOUT :
                  state_q == MEM_WAIT ? (hz.MEM_Ready_M ? RUN : (&wait_q ? TIMEOUT : MEM_WAIT)) :
                  (mem_stall ? MEM_WAIT : RUN);
    wait_d      = state_q == RUN ? (mem_stall ? 8'd1 : wait_q) :
                  (state_q == MEM_WAIT && !hz.MEM_Ready_M && !(&wait_q)) ? wait_q + 8'd1 : wait_q;
    timeout_d   = timeout_q || state_d == TIMEOUT;
    stall_cnt_d = stall_cnt_q + {15'd0, hz.Stall_F && stall_cnt_q != 16'hFFFF};
    flush_cnt_d = flush_cnt_q + {15'd0, hz.Flush_E && flush_cnt_q != 16'hFFFF};
  end
  // state registers, cleared by synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= RUN;
      wait_q      <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: scoreboard bench with a cycle-level behavioural hazard model
module tb_pipeline_hazard_controller;
  logic CLK, RST_N;
  pipeline_hazard_controller_if bus ();
  pipeline_hazard_controller dut (.CLK(CLK), .RST_N(RST_N), .hz(bus));

  typedef struct packed {
    logic [9:0]  ctl;
    logic [15:0] sc;
    logic [15:0] fc;
    logic        to;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   m_wait, m_to;
  int   m_len, m_sc, m_fc;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (bus.REG_W_En_M && bus.RD_M != 5'd0 && bus.RD_M == rs) return 2'b10;
    if (bus.REG_W_En_W && bus.RD_W != 5'd0 && bus.RD_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle();
    bus.RS1_D = 5'd0; bus.RS2_D = 5'd0; bus.RS1_E = 5'd0; bus.RS2_E = 5'd0;
    bus.RD_E = 5'd0; bus.RD_M = 5'd0; bus.RD_W = 5'd0;
    bus.REG_W_En_E = 1'b0; bus.REG_W_En_M = 1'b0; bus.REG_W_En_W = 1'b0;
    bus.Result_Src_Sel_E = 2'b00; bus.Mispredict_E = 1'b0;
    bus.MEM_Req_M = 1'b0; bus.MEM_Ready_M = 1'b1;
    RST_N = 1'b1;
  endtask

  task automatic rand_inputs();
    bus.RS1_D = 5'($urandom_range(0, 3)); bus.RS2_D = 5'($urandom_range(0, 3));
    bus.RS1_E = 5'($urandom_range(0, 3)); bus.RS2_E = 5'($urandom_range(0, 3));
    bus.RD_E = 5'($urandom_range(0, 3)); bus.RD_M = 5'($urandom_range(0, 3));
    bus.RD_W = 5'($urandom_range(0, 3));
    bus.REG_W_En_E = 1'($urandom_range(0, 1)); bus.REG_W_En_M = 1'($urandom_range(0, 1));
    bus.REG_W_En_W = 1'($urandom_range(0, 1));
    bus.Result_Src_Sel_E = 2'($urandom_range(0, 3));
    bus.Mispredict_E = ($urandom_range(0, 5) == 0);
    bus.MEM_Req_M = ($urandom_range(0, 3) == 0);
    bus.MEM_Ready_M = 1'($urandom_range(0, 1));
    RST_N = ($urandom_range(0, 149) != 0);
  endtask

  // one clock: predict outputs from the current inputs, queue them, then advance the model
  task automatic step();
    exp_t e;
    bit ms, free, mp, lu;
    ms   = m_to || (!bus.MEM_Ready_M && (m_wait || bus.MEM_Req_M));
    free = !m_to && !m_wait && !ms;
    mp   = free && bus.Mispredict_E;
    lu   = free && !bus.Mispredict_E && bus.Result_Src_Sel_E == 2'b01 && bus.REG_W_En_E &&
           bus.RD_E != 5'd0 && (bus.RD_E == bus.RS1_D || bus.RD_E == bus.RS2_D);
    if (!RST_N) e.ctl = 10'b0000_11_00_00;
    else e.ctl = {ms || lu, ms || lu, ms, ms, mp, mp || lu, fwd(bus.RS1_E), fwd(bus.RS2_E)};
    e.sc = 16'(m_sc);
    e.fc = 16'(m_fc);
    e.to = m_to;
    sbq.push_back(e);
    @(posedge CLK);
    if (!RST_N) begin
      m_wait = 0; m_to = 0; m_len = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (e.ctl[9] && m_sc < 65535) m_sc++;
      if (e.ctl[4] && m_fc < 65535) m_fc++;
      if (ms && !m_to) begin
        m_len++;
        if (m_len == 256) m_to = 1;
      end
      if (!ms) m_len = 0;
      m_wait = ms;
    end
    #1;
  endtask

  // monitor: compare DUT outputs against the oldest queued prediction on every falling edge
  always @(negedge CLK) begin
    exp_t e;
    logic [9:0] act;
    cyc++;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      act = {bus.Stall_F, bus.Stall_D, bus.Stall_E, bus.Stall_M, bus.Flush_D, bus.Flush_E, bus.Forward_A_E, bus.Forward_B_E};
      checks++;
      if (act !== e.ctl) begin
        failures++;
        $display("FAIL ctl cycle %0d: got %b expected %b (SF SD SE SM FD FE FA FB)", cyc, act, e.ctl);
      end
      checks++;
      if (bus.Stall_Count !== e.sc || bus.Flush_Count !== e.fc) begin
        failures++;
        $display("FAIL counters cycle %0d: got stall=%h flush=%h expected stall=%h flush=%h", cyc, bus.Stall_Count, bus.Flush_Count, e.sc, e.fc);
      end
      checks++;
      if (bus.Mem_Timeout !== e.to) begin
        failures++;
        $display("FAIL mem_timeout cycle %0d: got %b expected %b", cyc, bus.Mem_Timeout, e.to);
      end
    end
  end

  initial begin
    idle();
    RST_N = 1'b0;
    m_wait = 0; m_to = 0; m_len = 0; m_sc = 0; m_fc = 0;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      RST_N = 1'b0;
      step();
    end
    // load-use on RS1_D
    idle();
    bus.RD_E = 5'd5; bus.Result_Src_Sel_E = 2'b01; bus.REG_W_En_E = 1'b1; bus.RS1_D = 5'd5;
    step();
    idle();
    step();
    // forwarding priority and x0 exclusion
    bus.RD_M = 5'd7; bus.RD_W = 5'd7; bus.RS1_E = 5'd7; bus.RS2_E = 5'd7;
    bus.REG_W_En_M = 1'b1; bus.REG_W_En_W = 1'b1;
    step();
    bus.REG_W_En_M = 1'b0;
    step();
    bus.REG_W_En_M = 1'b1; bus.RD_M = 5'd0; bus.RS1_E = 5'd0;
    step();
    // three-cycle memory wait with a mispredict held across it
    idle();
    bus.MEM_Req_M = 1'b1; bus.MEM_Ready_M = 1'b0; bus.Mispredict_E = 1'b1;
    repeat (3) step();
    bus.MEM_Ready_M = 1'b1;
    step();
    bus.MEM_Req_M = 1'b0;
    step();
    // mispredict beats load-use
    idle();
    bus.Mispredict_E = 1'b1;
    bus.RD_E = 5'd3; bus.Result_Src_Sel_E = 2'b01; bus.REG_W_En_E = 1'b1; bus.RS2_D = 5'd3;
    step();
    idle();
    step();
    // random traffic
    repeat (2000) begin
      rand_inputs();
      step();
    end
    // timeout: ready held low for 300 cycles, then ready ignored, then reset
    idle();
    step();
    bus.MEM_Req_M = 1'b1; bus.MEM_Ready_M = 1'b0;
    repeat (300) step();
    bus.MEM_Ready_M = 1'b1;
    repeat (3) step();
    RST_N = 1'b0;
    step();
    idle();
    repeat (2) step();
    // saturation of both counters under continuous load-use
    bus.RD_E = 5'd9; bus.Result_Src_Sel_E = 2'b01; bus.REG_W_En_E = 1'b1; bus.RS1_D = 5'd9;
    repeat (70000) step();
    idle();
    repeat (2) step();
    @(negedge CLK);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
